// File: rtl/interrupt_sequencer_pkg.sv
// Shared encodings for the interrupt/reset entry sequencer: FSM states,
// request sources, data-bus selectors and the vector addresses.
package interrupt_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PUSH_PCH = 3'd1,
        S_PUSH_PCL = 3'd2,
        S_PUSH_P   = 3'd3,
        S_VEC_LO   = 3'd4,
        S_VEC_HI   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_IRQ  = 2'b01,
        SRC_NMI  = 2'b10,
        SRC_RST  = 2'b11
    } src_t;

    localparam logic [1:0] DSEL_NONE = 2'b00;
    localparam logic [1:0] DSEL_PCH  = 2'b01;
    localparam logic [1:0] DSEL_PCL  = 2'b10;
    localparam logic [1:0] DSEL_P    = 2'b11;

    localparam logic [15:0] VEC_NMI = 16'hFFFA;
    localparam logic [15:0] VEC_RST = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ = 16'hFFFE;

    localparam logic [7:0] STACK_PAGE = 8'h01;

    // Low byte address of the vector belonging to a source; high byte is +1.
    function automatic logic [15:0] vector_base(input src_t s);
        case (s)
            SRC_NMI: vector_base = VEC_NMI;
            SRC_RST: vector_base = VEC_RST;
            default: vector_base = VEC_IRQ;
        endcase
    endfunction

endpackage

// File: rtl/interrupt_sequencer_nmi.sv
// NMI falling-edge detector: one sample register plus a sticky pending flag
// that only the sequencer's acceptance of an NMI clears.
module nmi_edge_detect (
    input  logic clk,
    input  logic res,
    input  logic en,
    input  logic nmi,
    input  logic nmi_clr,
    output logic nmi_set,
    output logic pending
);

    logic nmi_q;

    // Edge is visible in the same cycle so a fall at a boundary wins over IRQ.
    assign nmi_set = nmi_q & ~nmi;

    always_ff @(posedge clk) begin
        if (res) begin
            nmi_q   <= 1'b1;
            pending <= 1'b0;
        end else if (en) begin
            nmi_q   <= nmi;
            pending <= (pending | nmi_set) & ~nmi_clr;
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// Five-cycle reset/NMI/IRQ entry sequencer: stacks PC and P (or dummy-reads
// for reset), then fetches the vector; outputs are Moore-decoded.
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        res,
    input  logic        rdy,
    input  logic        irq,
    input  logic        nmi,
    input  logic        boundary,
    input  logic        i_flag,
    input  logic [7:0]  sp,
    output logic        active,
    output logic [15:0] address,
    output logic        rw,
    output logic [1:0]  data_sel,
    output logic        sp_dec,
    output logic        pc_lo_load,
    output logic        pc_hi_load,
    output logic        set_i,
    output logic [1:0]  source
);

    state_t state_q, state_d;
    src_t   src_q, src_d;
    src_t   req_src;
    logic   rst_pending_q;
    logic   nmi_set, nmi_pending;
    logic   accept;

    nmi_edge_detect u_nmi (
        .clk     (clk),
        .res     (res),
        .en      (rdy),
        .nmi     (nmi),
        .nmi_clr (accept && (req_src == SRC_NMI)),
        .nmi_set (nmi_set),
        .pending (nmi_pending)
    );

    // Reset does not wait for an instruction boundary; NMI and IRQ do.
    always_comb begin
        req_src = SRC_NONE;
        if (rst_pending_q)
            req_src = SRC_RST;
        else if (boundary && (nmi_pending || nmi_set))
            req_src = SRC_NMI;
        else if (boundary && !irq && !i_flag)
            req_src = SRC_IRQ;
    end

    assign accept = (state_q == S_IDLE) && (req_src != SRC_NONE);

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_PUSH_PCH;
                    src_d   = req_src;
                end
            end
            S_PUSH_PCH: state_d = S_PUSH_PCL;
            S_PUSH_PCL: state_d = S_PUSH_P;
            S_PUSH_P:   state_d = S_VEC_LO;
            S_VEC_LO:   state_d = S_VEC_HI;
            S_VEC_HI: begin
                state_d = S_IDLE;
                src_d   = SRC_NONE;
            end
            default: begin
                state_d = S_IDLE;
                src_d   = SRC_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q       <= S_IDLE;
            src_q         <= SRC_NONE;
            rst_pending_q <= 1'b1;
        end else if (rdy) begin
            state_q <= state_d;
            src_q   <= src_d;
            if (accept && (req_src == SRC_RST))
                rst_pending_q <= 1'b0;
        end
    end

    // Reset entry performs the stack cycles as reads so nothing is written.
    always_comb begin
        address    = 16'h0000;
        rw         = 1'b1;
        data_sel   = DSEL_NONE;
        sp_dec     = 1'b0;
        pc_lo_load = 1'b0;
        pc_hi_load = 1'b0;
        set_i      = 1'b0;
        case (state_q)
            S_PUSH_PCH, S_PUSH_PCL, S_PUSH_P: begin
                address = {STACK_PAGE, sp};
                rw      = (src_q == SRC_RST);
                sp_dec  = 1'b1;
                if (state_q == S_PUSH_PCH)
                    data_sel = DSEL_PCH;
                else if (state_q == S_PUSH_PCL)
                    data_sel = DSEL_PCL;
                else
                    data_sel = DSEL_P;
            end
            S_VEC_LO: begin
                address    = vector_base(src_q);
                pc_lo_load = 1'b1;
            end
            S_VEC_HI: begin
                address    = vector_base(src_q) | 16'h0001;
                pc_hi_load = 1'b1;
                set_i      = 1'b1;
            end
            default: ;
        endcase
    end

    assign active = (state_q != S_IDLE);
    assign source = src_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench for interrupt_sequencer: stimulus queues the expected bus
// cycle for each clock of a sequence; a monitor checks whatever the DUT shows.
module tb_interrupt_sequencer;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        rdy = 1'b1;
    logic        irq = 1'b1;
    logic        nmi = 1'b1;
    logic        boundary = 1'b0;
    logic        i_flag = 1'b0;
    logic [7:0]  sp = 8'hFD;
    logic        active;
    logic [15:0] address;
    logic        rw;
    logic [1:0]  data_sel;
    logic        sp_dec;
    logic        pc_lo_load;
    logic        pc_hi_load;
    logic        set_i;
    logic [1:0]  source;

    interrupt_sequencer dut (
        .clk        (clk),
        .res        (res),
        .rdy        (rdy),
        .irq        (irq),
        .nmi        (nmi),
        .boundary   (boundary),
        .i_flag     (i_flag),
        .sp         (sp),
        .active     (active),
        .address    (address),
        .rw         (rw),
        .data_sel   (data_sel),
        .sp_dec     (sp_dec),
        .pc_lo_load (pc_lo_load),
        .pc_hi_load (pc_hi_load),
        .set_i      (set_i),
        .source     (source)
    );

    typedef struct packed {
        logic [31:0] cyc;
        logic [15:0] addr;
        logic        rw;
        logic [1:0]  ds;
        logic        spd;
        logic        lo;
        logic        hi;
        logic        si;
        logic [1:0]  src;
    } obs_t;

    obs_t        q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] cyc = 0;
    logic [31:0] c;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic obs_t mk(input logic [31:0] cc, input logic [15:0] a, input logic r,
                                input logic [1:0] ds, input logic spd, input logic lo,
                                input logic hi, input logic si, input logic [1:0] src);
        obs_t o;
        o = '{cc, a, r, ds, spd, lo, hi, si, src};
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Five expected bus cycles of a full sequence started by a request in cycle cc.
    task automatic push_seq(input logic [31:0] cc, input logic [1:0] src, input logic prw,
                            input logic [15:0] vlo, input logic [15:0] vhi);
        q.push_back(mk(cc + 1, 16'h01FD, prw, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, src));
        q.push_back(mk(cc + 2, 16'h01FD, prw, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, src));
        q.push_back(mk(cc + 3, 16'h01FD, prw, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, src));
        q.push_back(mk(cc + 4, vlo, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, src));
        q.push_back(mk(cc + 5, vhi, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, src));
    endtask

    task automatic check_idle(input string name);
        logic [26:0] got;
        got = {active, address, rw, data_sel, sp_dec, pc_lo_load, pc_hi_load, set_i, source};
        total++;
        if (got !== {1'b0, 16'h0000, 1'b1, 2'b00, 4'b0000, 2'b00}) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got,
                     {1'b0, 16'h0000, 1'b1, 2'b00, 4'b0000, 2'b00});
        end
    endtask

    always @(negedge clk) begin
        obs_t act;
        obs_t e;
        if (active === 1'b1) begin
            act = '{cyc, address, rw, data_sel, sp_dec, pc_lo_load, pc_hi_load, set_i, source};
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_active got=%h want=idle", act);
            end else begin
                e = q.pop_front();
                if (act !== e) begin
                    bad++;
                    $display("FAIL seq_step got=%h want=%h", act, e);
                end
            end
        end else if (q.size() > 0 && q[0].cyc <= cyc) begin
            total++;
            bad++;
            e = q.pop_front();
            $display("FAIL missing_step cyc=%0d got=idle want=%h", cyc, e);
        end
    end

    initial begin
        // Reset held two cycles, then the reset sequence with dummy reads.
        res = 1'b1;
        repeat (2) step();
        check_idle("reset_hold");
        res = 1'b0;
        c = cyc;
        push_seq(c, 2'b11, 1'b1, 16'hFFFC, 16'hFFFD);
        repeat (7) step();
        check_idle("after_reset");

        // Plain IRQ.
        irq = 1'b0; i_flag = 1'b0; boundary = 1'b1;
        c = cyc;
        push_seq(c, 2'b01, 1'b0, 16'hFFFE, 16'hFFFF);
        step();
        boundary = 1'b0; irq = 1'b1;
        repeat (6) step();
        check_idle("after_irq");

        // Masked IRQ never starts.
        irq = 1'b0; i_flag = 1'b1;
        for (int k = 0; k < 3; k++) begin
            boundary = 1'b1; step();
            boundary = 1'b0; step();
        end
        check_idle("irq_masked");
        irq = 1'b1; i_flag = 1'b0;

        // NMI edge and IRQ at the same boundary: NMI first, then IRQ.
        nmi = 1'b0; irq = 1'b0; boundary = 1'b1;
        c = cyc;
        push_seq(c, 2'b10, 1'b0, 16'hFFFA, 16'hFFFB);
        step();
        boundary = 1'b0;
        repeat (5) step();
        boundary = 1'b1;
        push_seq(cyc, 2'b01, 1'b0, 16'hFFFE, 16'hFFFF);
        step();
        boundary = 1'b0; irq = 1'b1;
        repeat (6) step();
        check_idle("after_priority");

        // NMI edge during an IRQ sequence is taken at the next boundary only once.
        nmi = 1'b1;
        repeat (2) step();
        irq = 1'b0; boundary = 1'b1;
        c = cyc;
        push_seq(c, 2'b01, 1'b0, 16'hFFFE, 16'hFFFF);
        step();
        boundary = 1'b0; irq = 1'b1;
        step();
        nmi = 1'b0;
        repeat (4) step();
        boundary = 1'b1;
        push_seq(cyc, 2'b10, 1'b0, 16'hFFFA, 16'hFFFB);
        step();
        boundary = 1'b0;
        repeat (6) step();
        for (int k = 0; k < 3; k++) begin
            boundary = 1'b1; step();
            boundary = 1'b0; step();
        end
        check_idle("no_third_seq");

        // rdy low for 3 cycles in PUSH_PCL; an NMI edge during the stall.
        nmi = 1'b1;
        repeat (2) step();
        irq = 1'b0; boundary = 1'b1;
        c = cyc;
        q.push_back(mk(c + 1, 16'h01FD, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01));
        for (int k = 2; k <= 5; k++)
            q.push_back(mk(c + k, 16'h01FD, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01));
        q.push_back(mk(c + 6, 16'h01FD, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01));
        q.push_back(mk(c + 7, 16'hFFFE, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01));
        q.push_back(mk(c + 8, 16'hFFFF, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01));
        step();
        boundary = 1'b0; irq = 1'b1;
        step();
        rdy = 1'b0;
        step();
        nmi = 1'b0;
        repeat (2) step();
        rdy = 1'b1;
        repeat (4) step();
        boundary = 1'b1;
        push_seq(cyc, 2'b10, 1'b0, 16'hFFFA, 16'hFFFB);
        step();
        boundary = 1'b0;
        repeat (6) step();
        check_idle("after_rdy");

        // Reset mid-sequence aborts it and drops a pending NMI.
        nmi = 1'b1;
        repeat (2) step();
        irq = 1'b0; boundary = 1'b1;
        c = cyc;
        q.push_back(mk(c + 1, 16'h01FD, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01));
        q.push_back(mk(c + 2, 16'h01FD, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01));
        step();
        boundary = 1'b0; irq = 1'b1; nmi = 1'b0;
        step();
        res = 1'b1; nmi = 1'b1;
        step();
        check_idle("abort_reset");
        res = 1'b0;
        push_seq(cyc, 2'b11, 1'b1, 16'hFFFC, 16'hFFFD);
        repeat (7) step();
        for (int k = 0; k < 2; k++) begin
            boundary = 1'b1; step();
            boundary = 1'b0; step();
        end
        check_idle("nmi_lost");

        repeat (3) step();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
